// File: rtl/zorro_dma_master_arb_pkg.sv
// Zorro II DMA bus-master sequencer: shared state encoding,
// output bundle and default timing constants.
package zorro_dma_master_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT_GRANT,
    WAIT_BUS,
    OWN,
    RELEASE,
    HOLDOFF
  } arb_state_e;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int TENURE_MAX_DEF    = 64;
  localparam int GRANT_TIMEOUT_DEF = 255;
  localparam int REREQ_GAP_DEF     = 4;
  localparam int CNT_W_DEF         = 8;

  typedef struct packed {
    logic brn;
    logic bgackn;
    logic bgack_oe;
    logic ownn;
    logic dma_gnt;
    logic grant_to;
  } arb_out_t;

  localparam arb_out_t OUT_IDLE = '{
    brn: 1'b1, bgackn: 1'b1, bgack_oe: 1'b0,
    ownn: 1'b1, dma_gnt: 1'b0, grant_to: 1'b0
  };

  localparam arb_out_t OUT_REQ = '{
    brn: 1'b0, bgackn: 1'b1, bgack_oe: 1'b0,
    ownn: 1'b1, dma_gnt: 1'b0, grant_to: 1'b0
  };

  localparam arb_out_t OUT_OWN = '{
    brn: 1'b1, bgackn: 1'b0, bgack_oe: 1'b1,
    ownn: 1'b0, dma_gnt: 1'b0, grant_to: 1'b0
  };

  // BGACK actively driven high for one cycle before tri-stating
  localparam arb_out_t OUT_REL = '{
    brn: 1'b1, bgackn: 1'b1, bgack_oe: 1'b1,
    ownn: 1'b1, dma_gnt: 1'b0, grant_to: 1'b0
  };

endpackage

// File: rtl/zorro_dma_master_arb_if.sv
// Slot-side bus and DMA-engine handshake signals of the
// Zorro II bus-master sequencer.
interface zorro_dma_master_arb_if;
  logic DMA_REQ;
  logic DMA_CYC;
  logic BGn;
  logic ASn;
  logic DTACKn;
  logic BGACKn_IN;
  logic BRn;
  logic BGACKn;
  logic BGACK_OE;
  logic OWNn;
  logic DMA_GNT;
  logic GRANT_TO;

  modport master (
    input  DMA_REQ, DMA_CYC, BGn, ASn,
    input  DTACKn, BGACKn_IN,
    output BRn, BGACKn, BGACK_OE, OWNn,
    output DMA_GNT, GRANT_TO
  );

  modport slave (
    output DMA_REQ, DMA_CYC, BGn, ASn,
    output DTACKn, BGACKn_IN,
    input  BRn, BGACKn, BGACK_OE, OWNn,
    input  DMA_GNT, GRANT_TO
  );
endinterface

// File: rtl/zorro_dma_master_arb_bus_sync.sv
// N-stage synchroniser for async bus strobes; resets to 1
// so the bus looks idle until real samples arrive.
module bus_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '1;
    else     ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/zorro_dma_master_arb.sv
// Zorro II card-side bus-mastership sequencer: BR/BG/BGACK
// handshake, tenure limit and grant timeout.
module zorro_dma_master_arb
  import zorro_dma_master_arb_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int TENURE_MAX    = TENURE_MAX_DEF,
  parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF,
  parameter int REREQ_GAP     = REREQ_GAP_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input logic C7M,
  input logic RESET,
  zorro_dma_master_arb_if.master bus
);

  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TENURE_MAX);
  localparam logic [CNT_W-1:0] GT_LAST = CNT_W'(GRANT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(REREQ_GAP - 1);

  arb_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  arb_out_t         out_q, out_nx;
  logic             bgn_s, asn_s, dtackn_s, bgackn_s;
  logic             expired, bus_free;

  bus_sync #(.N(SYNC_STAGES)) u_sync_bg (
    .clk(C7M), .rst(RESET), .d(bus.BGn), .q(bgn_s)
  );
  bus_sync #(.N(SYNC_STAGES)) u_sync_as (
    .clk(C7M), .rst(RESET), .d(bus.ASn), .q(asn_s)
  );
  bus_sync #(.N(SYNC_STAGES)) u_sync_dtack (
    .clk(C7M), .rst(RESET), .d(bus.DTACKn), .q(dtackn_s)
  );
  bus_sync #(.N(SYNC_STAGES)) u_sync_bgack (
    .clk(C7M), .rst(RESET), .d(bus.BGACKn_IN), .q(bgackn_s)
  );

  assign expired  = (TENURE_MAX != 0) && (cnt >= TMAX);
  assign bus_free = asn_s && dtackn_s && bgackn_s;

  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
      out_q <= OUT_IDLE;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      out_q <= out_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    out_nx          = out_q;
    out_nx.grant_to = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (bus.DMA_REQ) begin
          state_nx = REQUEST;
          out_nx   = OUT_REQ;
        end
      end
      REQUEST: state_nx = WAIT_GRANT;
      WAIT_GRANT: begin
        cnt_nx = cnt + 1'b1;
        // grant outranks a timeout landing in the same cycle
        if (!bgn_s) begin
          state_nx = WAIT_BUS;
        end else if (cnt == GT_LAST) begin
          state_nx        = HOLDOFF;
          cnt_nx          = '0;
          out_nx          = OUT_IDLE;
          out_nx.grant_to = 1'b1;
        end else if (!bus.DMA_REQ) begin
          state_nx = HOLDOFF;
          cnt_nx   = '0;
          out_nx   = OUT_IDLE;
        end
      end
      WAIT_BUS: begin
        if (bgn_s) begin
          state_nx = WAIT_GRANT;
        end else if (bus_free) begin
          state_nx = OWN;
          cnt_nx   = '0;
          out_nx   = OUT_OWN;
        end
      end
      OWN: begin
        if (TENURE_MAX != 0 && cnt < TMAX) cnt_nx = cnt + 1'b1;
        out_nx.dma_gnt = bus.DMA_REQ && !expired;
        // an in-flight engine cycle always completes first
        if ((!bus.DMA_REQ || expired) && !bus.DMA_CYC) begin
          state_nx = RELEASE;
          out_nx   = OUT_REL;
        end
      end
      RELEASE: begin
        state_nx = HOLDOFF;
        cnt_nx   = '0;
        out_nx   = OUT_IDLE;
      end
      HOLDOFF: begin
        cnt_nx = cnt + 1'b1;
        if (REREQ_GAP <= 1 || cnt == GAP_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        out_nx   = OUT_IDLE;
      end
    endcase
  end

  assign bus.BRn      = out_q.brn;
  assign bus.BGACKn   = out_q.bgackn;
  assign bus.BGACK_OE = out_q.bgack_oe;
  assign bus.OWNn     = out_q.ownn;
  assign bus.DMA_GNT  = out_q.dma_gnt;
  assign bus.GRANT_TO = out_q.grant_to;

endmodule
